pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 16-bit five-stage pipeline.
- Detects load-use hazards, instruction-memory structural conflicts, taken branches in ID, and multi-cycle slow data-memory accesses.
- Drives the keep/flush/bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Keeps a saturating stall-cycle counter for debug readout.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 13 +
 rtl/pipe_hazard_ctrl_slow_mem_timer.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// State encoding, the pipeline NOP word and the default register-id width.
package pipe_hazard_ctrl_pkg;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam logic [15:0] NOP_INSTR  = 16'h0800;
   localparam int          CTRL_REG_W = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_slow_mem_timer.sv
// Loadable down-counter with zero flag; counts the remaining frozen cycles
// of a slow data-memory access.
module slow_mem_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic [W-1:0] o_cnt,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: slow-memory freeze,
// load-use stall, IMEM structural conflict, taken branch, stall counter.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_RUN  | normal flow; a slow request freezes and enters ST_WAIT
//   ST_WAIT | freeze while timer != 0; timer == 0 releases to ST_RUN
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_W       = CTRL_REG_W,
   parameter int WAIT_CYCLES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rx,
   input  logic [REG_W-1:0] id_ry,
   input  logic             id_rx_used,
   input  logic             id_ry_used,
   input  logic             id_branch_taken,
   input  logic             ex_is_load,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_rd_we,
   input  logic             mem_imem_access,
   input  logic             mem_slow_req,
   input  logic             stall_clr,
   output logic             pc_keep,
   output logic             pc_sel_branch,
   output logic             ifkeep,
   output logic             if_flush,
   output logic             idex_keep,
   output logic             idex_bubble,
   output logic             exmem_keep,
   output logic             memwb_bubble,
   output logic             busy,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int TW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [TW-1:0] LOAD_VAL = TW'(WAIT_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_freeze;
   logic             w_load;
   logic             w_dec;
   logic             w_zero;
   logic             w_load_use;
   logic [TW-1:0]    w_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   slow_mem_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (LOAD_VAL),
      .i_dec      (w_dec),
      .o_cnt      (w_cnt),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // The release cycle ignores mem_slow_req: the frozen instruction is leaving.
   always_comb begin
      w_state_nxt = r_state;
      w_freeze    = 1'b0;
      w_load      = 1'b0;
      w_dec       = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (mem_slow_req) begin
               w_freeze    = 1'b1;
               w_load      = 1'b1;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!w_zero) begin
               w_freeze = 1'b1;
               w_dec    = 1'b1;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   assign w_load_use = ex_is_load && ex_rd_we &&
                       ((id_rx_used && (id_rx == ex_rd)) ||
                        (id_ry_used && (id_ry == ex_rd)));

   always_comb begin
      pc_keep       = 1'b0;
      pc_sel_branch = 1'b0;
      ifkeep        = 1'b0;
      if_flush      = 1'b0;
      idex_keep     = 1'b0;
      idex_bubble   = 1'b0;
      exmem_keep    = 1'b0;
      memwb_bubble  = 1'b0;
      if (!rst) begin
         if_flush     = 1'b1;
         idex_bubble  = 1'b1;
         memwb_bubble = 1'b1;
      end else if (w_freeze) begin
         pc_keep      = 1'b1;
         ifkeep       = 1'b1;
         idex_keep    = 1'b1;
         exmem_keep   = 1'b1;
         memwb_bubble = 1'b1;
      end else if (w_load_use) begin
         pc_keep     = 1'b1;
         ifkeep      = 1'b1;
         idex_bubble = 1'b1;
      end else if (mem_imem_access) begin
         if_flush = 1'b1;
         if (id_branch_taken) begin
            pc_sel_branch = 1'b1;
         end else begin
            pc_keep = 1'b1;
         end
      end else if (id_branch_taken) begin
         pc_sel_branch = 1'b1;
         if_flush      = 1'b1;
      end
   end

   assign busy = rst && (r_state == ST_WAIT);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stall_cnt <= '0;
      end else if (stall_clr) begin
         r_stall_cnt <= '0;
      end else if (pc_keep && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected
// control words; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst, rst1;
   logic [3:0] id_rx, id_ry, ex_rd;
   logic       id_rx_used, id_ry_used, id_branch_taken, ex_is_load, ex_rd_we;
   logic       mem_imem_access, mem_slow_req, mem_slow_req1, stall_clr;

   logic [8:0]  ctl0, ctl1;
   logic [15:0] cnt0, cnt1;

   always #5 clk = ~clk;

   // ctl = {pc_keep, pc_sel_branch, ifkeep, if_flush, idex_keep,
   //        idex_bubble, exmem_keep, memwb_bubble, busy}
   localparam logic [8:0] C_RST  = 9'b000101010;
   localparam logic [8:0] C_NONE = 9'b000000000;
   localparam logic [8:0] C_LU   = 9'b101001000;
   localparam logic [8:0] C_BR   = 9'b010100000;
   localparam logic [8:0] C_ST   = 9'b100100000;
   localparam logic [8:0] C_FRZ  = 9'b101010110;
   localparam logic [8:0] C_FRZB = 9'b101010111;
   localparam logic [8:0] C_BUSY = 9'b000000001;
   localparam logic [8:0] C_LUB  = 9'b101001001;

   pipe_hazard_ctrl #(.REG_W(4), .WAIT_CYCLES(2), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .id_rx(id_rx), .id_ry(id_ry),
      .id_rx_used(id_rx_used), .id_ry_used(id_ry_used),
      .id_branch_taken(id_branch_taken), .ex_is_load(ex_is_load),
      .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .mem_imem_access(mem_imem_access),
      .mem_slow_req(mem_slow_req), .stall_clr(stall_clr),
      .pc_keep(ctl0[8]), .pc_sel_branch(ctl0[7]), .ifkeep(ctl0[6]),
      .if_flush(ctl0[5]), .idex_keep(ctl0[4]), .idex_bubble(ctl0[3]),
      .exmem_keep(ctl0[2]), .memwb_bubble(ctl0[1]), .busy(ctl0[0]),
      .stall_cnt(cnt0)
   );

   pipe_hazard_ctrl #(.REG_W(4), .WAIT_CYCLES(1), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst1), .id_rx(id_rx), .id_ry(id_ry),
      .id_rx_used(id_rx_used), .id_ry_used(id_ry_used),
      .id_branch_taken(id_branch_taken), .ex_is_load(ex_is_load),
      .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .mem_imem_access(mem_imem_access),
      .mem_slow_req(mem_slow_req1), .stall_clr(stall_clr),
      .pc_keep(ctl1[8]), .pc_sel_branch(ctl1[7]), .ifkeep(ctl1[6]),
      .if_flush(ctl1[5]), .idex_keep(ctl1[4]), .idex_bubble(ctl1[3]),
      .exmem_keep(ctl1[2]), .memwb_bubble(ctl1[1]), .busy(ctl1[0]),
      .stall_cnt(cnt1)
   );

   typedef struct {
      string       name;
      logic [8:0]  ctl;
      logic [15:0] cnt;
      bit          sel;
   } entry_t;

   entry_t sb[$];
   int     total = 0;
   int     bad   = 0;

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         entry_t      e;
         logic [8:0]  gc;
         logic [15:0] gn;
         e  = sb.pop_front();
         gc = e.sel ? ctl1 : ctl0;
         gn = e.sel ? cnt1 : cnt0;
         total++;
         if (gc !== e.ctl || gn !== e.cnt) begin
            bad++;
            $display("FAIL %s: got ctl=%b cnt=%h, required ctl=%b cnt=%h",
                     e.name, gc, gn, e.ctl, e.cnt);
         end
      end
   end

   task automatic step(input string nm, input logic [8:0] c,
                       input logic [15:0] n, input bit s);
      entry_t e;
      e.name = nm; e.ctl = c; e.cnt = n; e.sel = s;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rx = 4'd0; id_ry = 4'd0; ex_rd = 4'd0;
      id_rx_used = 0; id_ry_used = 0; id_branch_taken = 0;
      ex_is_load = 0; ex_rd_we = 0; mem_imem_access = 0;
      mem_slow_req = 0; mem_slow_req1 = 0; stall_clr = 0;
   endtask

   task automatic load_use_rx3();
      ex_is_load = 1; ex_rd_we = 1; ex_rd = 4'd3;
      id_rx = 4'd3; id_rx_used = 1;
   endtask

   initial begin
      idle();
      rst = 0; rst1 = 0;
      @(posedge clk); #1;
      step("reset_state", C_RST, 16'd0, 0);
      rst = 1;
      step("idle_after_reset", C_NONE, 16'd0, 0);

      load_use_rx3(); id_branch_taken = 1;
      step("load_use_rx_branch", C_LU, 16'd0, 0);
      idle();
      step("load_use_one_cycle", C_NONE, 16'd1, 0);

      ex_is_load = 1; ex_rd_we = 1; ex_rd = 4'd5; id_ry = 4'd5; id_ry_used = 1;
      id_rx = 4'd2; id_rx_used = 1; mem_imem_access = 1;
      step("load_use_ry_struct", C_LU, 16'd1, 0);
      idle(); load_use_rx3(); id_rx_used = 0;
      step("load_use_unused_src", C_NONE, 16'd2, 0);
      idle(); load_use_rx3(); ex_rd_we = 0;
      step("load_use_no_we", C_NONE, 16'd2, 0);

      idle(); mem_imem_access = 1; id_branch_taken = 1;
      step("struct_branch", C_BR, 16'd2, 0);
      id_branch_taken = 0;
      step("struct_alone", C_ST, 16'd2, 0);
      idle(); id_branch_taken = 1;
      step("branch_alone", C_BR, 16'd3, 0);

      idle(); mem_slow_req = 1;
      step("slow_c0", C_FRZ, 16'd3, 0);
      step("slow_c1", C_FRZB, 16'd4, 0);
      step("slow_c2_release", C_BUSY, 16'd5, 0);
      idle();
      step("slow_after", C_NONE, 16'd5, 0);

      mem_slow_req = 1; load_use_rx3();
      step("frz_hazard_c0", C_FRZ, 16'd5, 0);
      mem_slow_req = 0;
      step("frz_hazard_c1", C_FRZB, 16'd6, 0);
      step("frz_release_lu", C_LUB, 16'd7, 0);
      idle();
      step("frz_hazard_after", C_NONE, 16'd8, 0);

      mem_slow_req = 1;
      step("rstwait_c0", C_FRZ, 16'd8, 0);
      rst = 0;
      step("rstwait_in_reset", C_RST, 16'd9, 0);
      rst = 1; mem_slow_req = 0;
      step("rstwait_no_residual", C_NONE, 16'd0, 0);

      mem_imem_access = 1;
      step("clr_pre", C_ST, 16'd0, 0);
      stall_clr = 1;
      step("clr_with_keep", C_ST, 16'd1, 0);
      idle();
      step("clr_result", C_NONE, 16'd0, 0);

      mem_imem_access = 1;
      for (int i = 0; i < 65535; i++) begin
         @(posedge clk); #1;
      end
      step("sat_reach", C_ST, 16'hFFFF, 0);
      step("sat_hold", C_ST, 16'hFFFF, 0);
      idle(); stall_clr = 1;
      step("sat_clr_issue", C_NONE, 16'hFFFF, 0);
      stall_clr = 0;
      step("sat_clr_result", C_NONE, 16'h0000, 0);

      rst1 = 1;
      step("w1_idle", C_NONE, 16'd0, 1);
      mem_slow_req1 = 1;
      step("w1_c0", C_FRZ, 16'd0, 1);
      step("w1_c1_release", C_BUSY, 16'd1, 1);
      mem_slow_req1 = 0;
      step("w1_after", C_NONE, 16'd1, 1);

      @(negedge clk); #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
